// File: rtl/layer_norm_stats_if.sv
// Configuration, input-lane and result bundle for layer_norm_stats.
// The driver (testbench or upstream block) uses master; the statistics block uses slave.
interface layer_norm_stats_if #(
  parameter int BUS_NUM        = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_NUM_WIDTH = 10
);
  localparam int SUM_W = DATA_WIDTH + DATA_NUM_WIDTH;
  localparam int SQ_W  = 2*DATA_WIDTH + DATA_NUM_WIDTH;
  localparam int VAR_W = 2*SQ_W;

  logic [DATA_NUM_WIDTH-1:0]       in_data_num;
  logic                            in_data_num_vld;
  logic                            in_mode;
  logic                            in_mode_vld;
  logic [BUS_NUM*DATA_WIDTH-1:0]   in_fixed_data;
  logic [BUS_NUM-1:0]              in_fixed_data_vld;
  logic                            in_ready;
  logic signed [SUM_W-1:0]         out_sum;
  logic [SQ_W-1:0]                 out_sumsq;
  logic [VAR_W-1:0]                out_var_num;
  logic                            out_vld;
  logic                            out_err;

  modport master (
    output in_data_num, in_data_num_vld, in_mode, in_mode_vld,
           in_fixed_data, in_fixed_data_vld,
    input  in_ready, out_sum, out_sumsq, out_var_num, out_vld, out_err
  );

  modport slave (
    input  in_data_num, in_data_num_vld, in_mode, in_mode_vld,
           in_fixed_data, in_fixed_data_vld,
    output in_ready, out_sum, out_sumsq, out_var_num, out_vld, out_err
  );
endinterface

// File: rtl/layer_norm_stats.sv
// Row statistics for LayerNorm/RMSNorm: accumulates sum and sum of squares over a row of
// data_num signed elements and reports N*sumsq - sum^2 (or N*sumsq in RMS mode).
module layer_norm_stats #(
  parameter int BUS_NUM        = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_NUM_WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  layer_norm_stats_if.slave bus
);
  localparam int SUM_W = DATA_WIDTH + DATA_NUM_WIDTH;
  localparam int SQ_W  = 2*DATA_WIDTH + DATA_NUM_WIDTH;
  localparam int VAR_W = 2*SQ_W;
  localparam int CNT_W = DATA_NUM_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_FINAL = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                      state_r;
  state_t                      state_s;
  logic [DATA_NUM_WIDTH-1:0]   data_num_r;
  logic                        mode_r;
  logic [DATA_NUM_WIDTH-1:0]   row_num_r;
  logic                        row_mode_r;
  logic [DATA_NUM_WIDTH-1:0]   count_r;
  logic signed [SUM_W-1:0]     sum_r;
  logic [SQ_W-1:0]             sumsq_r;
  logic                        in_ready_r;
  logic                        out_vld_r;
  logic                        out_err_r;
  logic signed [SUM_W-1:0]     out_sum_r;
  logic [SQ_W-1:0]             out_sumsq_r;
  logic [VAR_W-1:0]            out_var_r;

  logic [DATA_NUM_WIDTH-1:0]   limit_s;
  logic [DATA_NUM_WIDTH-1:0]   base_s;
  logic [CNT_W-1:0]            remain_s;
  logic [CNT_W-1:0]            taken_s;
  logic [CNT_W-1:0]            total_s;
  logic signed [SUM_W-1:0]     beat_sum_s;
  logic [SQ_W-1:0]             beat_sq_s;
  logic                        drop_s;
  logic                        accept_s;
  logic                        row_done_s;
  logic [SUM_W-1:0]            sum_mag_s;
  logic [VAR_W-1:0]            n_sq_s;
  logic [VAR_W-1:0]            sum2_s;
  logic [VAR_W-1:0]            var_s;

  // Lane selection: take the lowest-indexed valid lanes up to the elements still owed to the row.
  // In IDLE the row has not started yet, so the freshly latched data_num is the limit.
  always_comb begin
    logic signed [DATA_WIDTH-1:0]   lane_v;
    logic signed [2*DATA_WIDTH-1:0] lane_x;
    logic signed [2*DATA_WIDTH-1:0] sq_v;
    limit_s    = (state_r == S_IDLE) ? data_num_r : row_num_r;
    base_s     = (state_r == S_IDLE) ? {DATA_NUM_WIDTH{1'b0}} : count_r;
    remain_s   = {1'b0, limit_s} - {1'b0, base_s};
    taken_s    = {CNT_W{1'b0}};
    beat_sum_s = {SUM_W{1'b0}};
    beat_sq_s  = {SQ_W{1'b0}};
    drop_s     = 1'b0;
    lane_v     = {DATA_WIDTH{1'b0}};
    lane_x     = {2*DATA_WIDTH{1'b0}};
    sq_v       = {2*DATA_WIDTH{1'b0}};
    for (int i = 0; i < BUS_NUM; i++) begin
      lane_v = bus.in_fixed_data[i*DATA_WIDTH +: DATA_WIDTH];
      lane_x = {{DATA_WIDTH{lane_v[DATA_WIDTH-1]}}, lane_v};
      sq_v   = lane_x * lane_x;
      if (bus.in_fixed_data_vld[i] && (taken_s < remain_s)) begin
        taken_s    = taken_s + {{(CNT_W-1){1'b0}}, 1'b1};
        beat_sum_s = beat_sum_s + {{(SUM_W-DATA_WIDTH){lane_v[DATA_WIDTH-1]}}, lane_v};
        beat_sq_s  = beat_sq_s + {{(SQ_W-2*DATA_WIDTH){1'b0}}, sq_v};
      end else if (bus.in_fixed_data_vld[i]) begin
        drop_s = 1'b1;
      end else begin
        drop_s = drop_s;
      end
    end
    accept_s   = in_ready_r && (|bus.in_fixed_data_vld) && (limit_s != {DATA_NUM_WIDTH{1'b0}});
    total_s    = {1'b0, base_s} + taken_s;
    row_done_s = (total_s == {1'b0, limit_s});
  end

  // Final statistic; |sum|^2 <= N*sumsq (Cauchy-Schwarz) so the subtraction never wraps.
  always_comb begin
    sum_mag_s = sum_r[SUM_W-1] ? $unsigned(-sum_r) : $unsigned(sum_r);
    n_sq_s    = VAR_W'(row_num_r) * VAR_W'(sumsq_r);
    sum2_s    = VAR_W'(sum_mag_s) * VAR_W'(sum_mag_s);
    if (row_mode_r) begin
      var_s = n_sq_s;
    end else begin
      var_s = n_sq_s - sum2_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = row_done_s ? S_FINAL : S_ACC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACC: begin
        if (accept_s && row_done_s) begin
          state_s = S_FINAL;
        end else begin
          state_s = S_ACC;
        end
      end
      S_FINAL: state_s = S_OUT;
      S_OUT:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Configuration latches; written in any state, snapshotted per row on its first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_num_r <= {DATA_NUM_WIDTH{1'b0}};
      mode_r     <= 1'b0;
    end else begin
      if (bus.in_data_num_vld) begin
        data_num_r <= bus.in_data_num;
      end
      if (bus.in_mode_vld) begin
        mode_r <= bus.in_mode;
      end
    end
  end

  // Row accumulators; the first beat of a row restarts them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_num_r  <= {DATA_NUM_WIDTH{1'b0}};
      row_mode_r <= 1'b0;
      count_r    <= {DATA_NUM_WIDTH{1'b0}};
      sum_r      <= {SUM_W{1'b0}};
      sumsq_r    <= {SQ_W{1'b0}};
    end else if (accept_s) begin
      count_r <= total_s[DATA_NUM_WIDTH-1:0];
      if (state_r == S_IDLE) begin
        row_num_r  <= data_num_r;
        row_mode_r <= mode_r;
        sum_r      <= beat_sum_s;
        sumsq_r    <= beat_sq_s;
      end else begin
        sum_r   <= sum_r + beat_sum_s;
        sumsq_r <= sumsq_r + beat_sq_s;
      end
    end
  end

  // Registered handshake, strobes and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_vld_r   <= 1'b0;
      out_err_r   <= 1'b0;
      out_sum_r   <= {SUM_W{1'b0}};
      out_sumsq_r <= {SQ_W{1'b0}};
      out_var_r   <= {VAR_W{1'b0}};
    end else begin
      in_ready_r <= (state_s == S_IDLE) || (state_s == S_ACC);
      out_vld_r  <= (state_r == S_FINAL);
      out_err_r  <= accept_s && drop_s;
      if (state_r == S_FINAL) begin
        out_sum_r   <= row_mode_r ? {SUM_W{1'b0}} : sum_r;
        out_sumsq_r <= sumsq_r;
        out_var_r   <= var_s;
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_vld     = out_vld_r;
  assign bus.out_err     = out_err_r;
  assign bus.out_sum     = out_sum_r;
  assign bus.out_sumsq   = out_sumsq_r;
  assign bus.out_var_num = out_var_r;
endmodule

// File: doc/layer_norm_stats.md
LAYER_NORM_STATS -- requirements
Module: layer_norm_stats

Interface
REQ-001 SHALL have parameter BUS_NUM, default 8: number of input lanes per beat.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: signed width of each lane.
REQ-003 SHALL have parameter DATA_NUM_WIDTH, default 10: width of the per-row element count.
REQ-004 SHALL have derived localparams SUM_W=DATA_WIDTH+DATA_NUM_WIDTH, SQ_W=2*DATA_WIDTH+DATA_NUM_WIDTH and VAR_W=2*SQ_W.
REQ-005 SHALL have ports, in order:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_data_num  in  DATA_NUM_WIDTH  elements per row
- in_data_num_vld  in  1  load in_data_num
- in_mode  in  1  0=LayerNorm, 1=RMSNorm
- in_mode_vld  in  1  load in_mode
- in_fixed_data  in  BUS_NUM*DATA_WIDTH  signed lanes; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_fixed_data_vld  in  BUS_NUM  per-lane valid
- in_ready  out  1  block accepts a beat this cycle
- out_sum  out  SUM_W  signed row sum
- out_sumsq  out  SQ_W  unsigned row sum of squares
- out_var_num  out  VAR_W  unsigned N*sumsq - sum^2
- out_vld  out  1  one-cycle result strobe
- out_err  out  1  one-cycle overrun strobe

Function
REQ-006 SHALL register data_num and mode on their vld strobes in any state; a row uses the values latched when its first beat is accepted.
REQ-007 SHALL implement an FSM with states IDLE, ACC, FINAL and OUT.
REQ-008 SHALL drive in_ready=1 in IDLE and ACC, and in_ready=0 in FINAL and OUT.
REQ-009 SHALL accept a beat only when in_ready=1 and in_fixed_data_vld is nonzero; all-zero vld beats SHALL have no effect.
REQ-010 IDLE SHALL go to ACC on the first accepted beat, clear the accumulators, and count that beat.
REQ-011 A row SHALL be ignored and the FSM SHALL stay in IDLE when the latched data_num is 0.
REQ-012 SHALL sum only the valid lanes of each accepted beat:
- sum += sign-extended x
- sumsq += x*x
- count += popcount(vld)
REQ-013 SHALL accept only the lowest-indexed valid lanes, up to the remaining element count, when a beat's valid lanes exceed that count; it SHALL drop the rest and pulse out_err the next cycle.
REQ-014 SHALL go to FINAL on the cycle that count reaches data_num; FINAL SHALL register out_var_num = data_num*sumsq - sum*sum.
REQ-015 OUT SHALL assert out_vld for exactly one cycle, then return to IDLE; the last beat accepted at cycle t SHALL give out_vld at t+2 and in_ready=1 again at t+3.
REQ-016 In RMS mode, out_sum SHALL be 0 and out_var_num SHALL be data_num*sumsq.
REQ-017 out_sum, out_sumsq and out_var_num SHALL hold their values until the next OUT state.
REQ-018 No arithmetic SHALL overflow for data_num up to 2^DATA_NUM_WIDTH-1 at full-scale inputs; out_var_num SHALL be nonnegative by construction.
REQ-019 A data_num write during ACC SHALL NOT affect the current row.

Reset
REQ-020 Asserting rst_n low at any time, including mid-row, SHALL asynchronously force:
- FSM to IDLE
- accumulators, count, data_num, mode and all outputs to 0
- in_ready to 0 while rst_n is low, and 1 from the first clock after release.

Verification
REQ-021 The bench SHALL cover:
- data_num=8, mode=0, one beat of lanes 1..8 all valid -> out_sum=36, out_sumsq=204, out_var_num=336, out_vld at t+2.
- data_num=8, mode=1, all lanes -3 -> out_sum=0, out_sumsq=72, out_var_num=576.
- data_num=5, mode=0, one beat of 8 valid lanes of 2 -> lanes 0..4 accepted, out_sum=10, out_sumsq=20, out_var_num=0, out_err pulses once.
- data_num=16, two beats of all -128 with a gap beat of vld=0 between them -> out_sum=-2048, out_sumsq=262144, out_var_num=0.
- rst_n pulsed low after the first of two beats, then a fresh 8-element row -> only the fresh row is reported, one out_vld.
- data_num=0 with beats presented -> no out_vld, FSM remains IDLE, in_ready stays 1.
